// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - ALUOp codes, funct constants and FSM states for the execute stage
package ex_pkg;
   localparam logic [2:0] ALUOP_LS = 3'b000;
   localparam logic [2:0] ALUOP_BR = 3'b001;
   localparam logic [2:0] ALUOP_R  = 3'b010;
   localparam logic [2:0] ALUOP_I  = 3'b011;

   localparam logic [9:0] FUNCT_AND  = 10'b0000000_111;
   localparam logic [9:0] FUNCT_XOR  = 10'b0000000_100;
   localparam logic [9:0] FUNCT_SLL  = 10'b0000000_001;
   localparam logic [9:0] FUNCT_ADD  = 10'b0000000_000;
   localparam logic [9:0] FUNCT_SUB  = 10'b0100000_000;
   localparam logic [9:0] FUNCT_MUL  = 10'b0000001_000;
   localparam logic [9:0] FUNCT_SRAI = 10'b0100000_101;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_SRAI = 3'b101;

   typedef enum logic [1:0] {IDLE, RUN, DONE} ex_state_e;
endpackage

// File: rtl/ex_stage_mul_iter.sv
// rtl/ex_stage_mul_iter.sv - 32-step iterative shift-add multiplier
module mul_iter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] product_o
);
   logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start_i) begin
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 5'd1;
         if (cnt_q == 5'd31) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   // done marks the cycle performing the last step; the product is final one edge later
   assign busy_o    = busy_q;
   assign done_o    = busy_q && (cnt_q == 5'd31);
   assign product_o = acc_q;
endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU, iterative MUL FSM and EX/MEM register
module ex_stage
   import ex_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [2:0]  ALUOp_i,
   input  logic        ALUSrc_i,
   input  logic        RegWrite_i,
   input  logic        MemWrite_i,
   input  logic        MemRead_i,
   input  logic        MemtoReg_i,
   input  logic [31:0] RS1data_i,
   input  logic [31:0] RS2data_i,
   input  logic [31:0] imm_i,
   input  logic [9:0]  funct_i,
   input  logic [4:0]  RDaddr_i,
   input  logic [4:0]  RSaddr_i,
   input  logic [4:0]  RTaddr_i,
   input  logic        MEMWB_RegWrite_i,
   input  logic [4:0]  MEMWB_RDaddr_i,
   input  logic [31:0] MEMWB_data_i,
   output logic        RegWrite_o,
   output logic        MemWrite_o,
   output logic        MemRead_o,
   output logic        MemtoReg_o,
   output logic [31:0] ALUresult_o,
   output logic [31:0] MemWdata_o,
   output logic [4:0]  RDaddr_o,
   output logic        stall_o
);
   ex_state_e   state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d, hold_ctrl_q, hold_ctrl_d;
   logic [31:0] res_q, res_d, wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d, hold_rd_q, hold_rd_d;
   logic [31:0] fwd_a, fwd_b, op_b, alu_res, product;
   logic        is_mul, mul_start, mul_busy, mul_done;

   always_comb begin
      fwd_a = RS1data_i;
      if (ctrl_q[3] && rd_q == RSaddr_i && RSaddr_i != 5'd0) fwd_a = res_q;
      else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i == RSaddr_i && RSaddr_i != 5'd0) fwd_a = MEMWB_data_i;
      fwd_b = RS2data_i;
      if (ctrl_q[3] && rd_q == RTaddr_i && RTaddr_i != 5'd0) fwd_b = res_q;
      else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i == RTaddr_i && RTaddr_i != 5'd0) fwd_b = MEMWB_data_i;
      op_b = ALUSrc_i ? imm_i : fwd_b;
   end

   always_comb begin
      alu_res = '0;
      case (ALUOp_i)
         ALUOP_LS: alu_res = fwd_a + op_b;
         ALUOP_BR: alu_res = fwd_a - op_b;
         ALUOP_R: begin
            case (funct_i)
               FUNCT_AND: alu_res = fwd_a & op_b;
               FUNCT_XOR: alu_res = fwd_a ^ op_b;
               FUNCT_SLL: alu_res = fwd_a << op_b[4:0];
               FUNCT_ADD: alu_res = fwd_a + op_b;
               FUNCT_SUB: alu_res = fwd_a - op_b;
               default:   alu_res = '0;
            endcase
         end
         ALUOP_I: begin
            case (funct_i[2:0])
               F3_ADDI: alu_res = fwd_a + op_b;
               F3_SRAI: alu_res = $signed(fwd_a) >>> op_b[4:0];
               default: alu_res = '0;
            endcase
         end
         default: alu_res = '0;
      endcase
   end

   assign is_mul = (ALUOp_i == ALUOP_R) && (funct_i == FUNCT_MUL);

   mul_iter u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (mul_start),
      .a_i       (fwd_a),
      .b_i       (op_b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (product)
   );

   // Unless explicitly loaded, EX/MEM receives a bubble
   always_comb begin
      state_d     = state_q;
      ctrl_d      = '0;
      res_d       = '0;
      wdata_d     = '0;
      rd_d        = '0;
      hold_ctrl_d = hold_ctrl_q;
      hold_rd_d   = hold_rd_q;
      mul_start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_mul) begin
               mul_start   = 1'b1;
               hold_ctrl_d = {RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i};
               hold_rd_d   = RDaddr_i;
               state_d     = RUN;
            end else begin
               ctrl_d  = {RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i};
               res_d   = alu_res;
               wdata_d = fwd_b;
               rd_d    = RDaddr_i;
            end
         end
         RUN: if (mul_done) state_d = DONE;
         DONE: begin
            ctrl_d  = hold_ctrl_q;
            res_d   = product;
            rd_d    = hold_rd_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         ctrl_q      <= '0;
         res_q       <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         hold_ctrl_q <= '0;
         hold_rd_q   <= '0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         res_q       <= res_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         hold_ctrl_q <= hold_ctrl_d;
         hold_rd_q   <= hold_rd_d;
      end
   end

   assign stall_o = !rst_i && ((state_q == IDLE && is_mul) || state_q == RUN || mul_busy);
   assign {RegWrite_o, MemWrite_o, MemRead_o, MemtoReg_o} = ctrl_q;
   assign ALUresult_o = res_q;
   assign MemWdata_o  = wdata_q;
   assign RDaddr_o    = rd_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [2:0]  ALUOp_i;
   logic        ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i;
   logic [31:0] RS1data_i, RS2data_i, imm_i;
   logic [9:0]  funct_i;
   logic [4:0]  RDaddr_i, RSaddr_i, RTaddr_i;
   logic        MEMWB_RegWrite_i;
   logic [4:0]  MEMWB_RDaddr_i;
   logic [31:0] MEMWB_data_i;
   logic        RegWrite_o, MemWrite_o, MemRead_o, MemtoReg_o;
   logic [31:0] ALUresult_o, MemWdata_o;
   logic [4:0]  RDaddr_o;
   logic        stall_o;

   always #5 clk_i = ~clk_i;

   ex_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
      .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
      .MemtoReg_i(MemtoReg_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
      .imm_i(imm_i), .funct_i(funct_i), .RDaddr_i(RDaddr_i), .RSaddr_i(RSaddr_i),
      .RTaddr_i(RTaddr_i), .MEMWB_RegWrite_i(MEMWB_RegWrite_i),
      .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_data_i(MEMWB_data_i),
      .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
      .MemtoReg_o(MemtoReg_o), .ALUresult_o(ALUresult_o), .MemWdata_o(MemWdata_o),
      .RDaddr_o(RDaddr_o), .stall_o(stall_o)
   );

   int errors = 0;
   int checks = 0;

   // Expected EX/MEM register contents
   logic        m_rw, m_mw, m_mr, m_m2r;
   logic [31:0] m_res, m_wd;
   logic [4:0]  m_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_exmem(input string tag);
      check({tag, ".RegWrite"}, 32'(RegWrite_o), 32'(m_rw));
      check({tag, ".MemWrite"}, 32'(MemWrite_o), 32'(m_mw));
      check({tag, ".MemRead"},  32'(MemRead_o),  32'(m_mr));
      check({tag, ".MemtoReg"}, 32'(MemtoReg_o), 32'(m_m2r));
      check({tag, ".ALUresult"}, ALUresult_o, m_res);
      check({tag, ".MemWdata"},  MemWdata_o,  m_wd);
      check({tag, ".RDaddr"},    32'(RDaddr_o), 32'(m_rd));
   endtask

   task automatic model_clear();
      {m_rw, m_mw, m_mr, m_m2r} = 4'b0;
      m_res = 0; m_wd = 0; m_rd = 0;
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] rf);
      if (addr == 0) return rf;
      if (m_rw && m_rd == addr) return m_res;
      if (MEMWB_RegWrite_i && MEMWB_RDaddr_i == addr) return MEMWB_data_i;
      return rf;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [9:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: case (f)
            10'b0000000_111: return a & b;
            10'b0000000_100: return a ^ b;
            10'b0000000_001: return a << sh;
            10'b0000000_000: return a + b;
            10'b0100000_000: return a - b;
            default:         return 0;
         endcase
         3'd3: begin
            if (f[2:0] == 3'b000) return a + b;
            if (f[2:0] == 3'b101) return 32'($signed(a) >>> sh);
            return 0;
         end
         default: return 0;
      endcase
   endfunction

   task automatic set_instr(input logic [2:0] op, input logic src, input logic [3:0] ctrl,
                            input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                            input logic [9:0] f, input logic [4:0] rd, input logic [4:0] rs,
                            input logic [4:0] rt);
      ALUOp_i = op; ALUSrc_i = src;
      {RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i} = ctrl;
      RS1data_i = r1; RS2data_i = r2; imm_i = imm; funct_i = f;
      RDaddr_i = rd; RSaddr_i = rs; RTaddr_i = rt;
   endtask

   task automatic set_wb(input logic rw, input logic [4:0] rd, input logic [31:0] d);
      MEMWB_RegWrite_i = rw; MEMWB_RDaddr_i = rd; MEMWB_data_i = d;
   endtask

   // Issues the instruction currently on the inputs and checks every cycle until it retires
   task automatic run_instr(input string tag);
      logic [31:0] a, rs2f, b, prod;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      bit          mul;
      a    = fwd(RSaddr_i, RS1data_i);
      rs2f = fwd(RTaddr_i, RS2data_i);
      b    = ALUSrc_i ? imm_i : rs2f;
      mul  = (ALUOp_i == 3'd2) && (funct_i == 10'b0000001_000);
      ctrl = {RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i};
      rd   = RDaddr_i;
      #1;
      if (!mul) begin
         check({tag, ".stall"}, 32'(stall_o), 0);
         @(posedge clk_i); #1;
         {m_rw, m_mw, m_mr, m_m2r} = ctrl;
         m_res = ref_alu(ALUOp_i, funct_i, a, b);
         m_wd  = rs2f;
         m_rd  = rd;
         check_exmem(tag);
      end else begin
         prod = a * b;
         check({tag, ".stall_entry"}, 32'(stall_o), 1);
         for (int k = 1; k <= 33; k++) begin
            @(posedge clk_i); #1;
            model_clear();
            check_exmem({tag, ".bubble"});
            check({tag, ".stall_run"}, 32'(stall_o), 32'(k < 33));
            set_wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
         end
         @(posedge clk_i); #1;
         {m_rw, m_mw, m_mr, m_m2r} = ctrl;
         m_res = prod;
         m_wd  = 0;
         m_rd  = rd;
         check_exmem({tag, ".product"});
      end
   endtask

   localparam logic [9:0] F_ADD = 10'b0000000_000;
   localparam logic [9:0] F_SUB = 10'b0100000_000;
   localparam logic [9:0] F_MUL = 10'b0000001_000;

   initial begin
      logic [9:0] rfun [7];
      rfun = '{10'b0000000_111, 10'b0000000_100, 10'b0000000_001, F_ADD, F_SUB, F_MUL, 10'b1010101_010};
      rst_i = 1'b1;
      set_wb(0, 0, 0);
      set_instr(3'd2, 0, 4'b1000, 6, 7, 0, F_MUL, 3, 1, 2);
      model_clear();
      #12;
      check("reset.stall_forced_low", 32'(stall_o), 0);
      check_exmem("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      set_instr(3'd2, 0, 4'b1000, 5, 7, 0, F_ADD, 3, 1, 2);
      run_instr("add_5_7");
      check("add_5_7.value", ALUresult_o, 12);

      set_instr(3'd3, 1, 4'b1000, 32'h8000_0000, 0, 32'h404, 10'b0100000_101, 5, 6, 0);
      run_instr("srai");
      check("srai.value", ALUresult_o, 32'hF800_0000);

      set_instr(3'd2, 0, 4'b1000, 15, 5, 0, F_ADD, 1, 7, 8);
      run_instr("add_x1");
      set_wb(1, 1, 9);
      set_instr(3'd2, 0, 4'b1000, 32'h55, 3, 0, F_SUB, 4, 1, 2);
      run_instr("fwd_priority");
      check("fwd_priority.value", ALUresult_o, 17);

      set_wb(0, 0, 0);
      set_instr(3'd2, 0, 4'b1000, 15, 5, 0, F_ADD, 0, 7, 8);
      run_instr("add_x0");
      set_wb(1, 0, 9);
      set_instr(3'd2, 0, 4'b1000, 50, 3, 0, F_SUB, 4, 0, 2);
      run_instr("x0_no_fwd");
      check("x0_no_fwd.value", ALUresult_o, 47);

      set_wb(0, 0, 0);
      set_instr(3'd2, 0, 4'b1000, 32'hFFFF_FFFF, 3, 0, F_MUL, 7, 9, 10);
      run_instr("mul");
      check("mul.value", ALUresult_o, 32'hFFFF_FFFD);

      set_wb(1, 12, 32'hDEAD);
      set_instr(3'd0, 1, 4'b0100, 32'h100, 32'h1234, 8, F_ADD, 0, 11, 12);
      run_instr("sw");
      check("sw.addr", ALUresult_o, 32'h108);
      check("sw.wdata", MemWdata_o, 32'hDEAD);

      set_wb(0, 0, 0);
      set_instr(3'd2, 0, 4'b1000, 123, 456, 0, F_MUL, 8, 13, 14);
      #1;
      check("rst_mid.stall_entry", 32'(stall_o), 1);
      repeat (11) @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      model_clear();
      check("rst_mid.stall", 32'(stall_o), 0);
      check_exmem("rst_mid");
      @(negedge clk_i);
      rst_i = 1'b0;
      set_instr(3'd2, 0, 4'b1000, 40, 2, 0, F_ADD, 9, 15, 16);
      run_instr("after_rst");
      check("after_rst.value", ALUresult_o, 42);

      for (int i = 0; i < 150; i++) begin
         int r;
         logic [2:0] op;
         logic [9:0] f;
         r = $urandom_range(0, 9);
         f = 10'($urandom);
         if (r < 2) op = 3'd0;
         else if (r == 2) op = 3'd1;
         else if (r < 7) begin
            op = 3'd2;
            f  = rfun[$urandom_range(0, 6)];
         end else if (r < 9) begin
            op = 3'd3;
            if ($urandom_range(0, 2) == 0) f[2:0] = 3'b000;
            else if ($urandom_range(0, 1) == 0) f[2:0] = 3'b101;
         end else op = 3'($urandom_range(4, 7));
         set_wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
         set_instr(op, 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, f,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         run_instr("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
